// File: rtl/rev_pkg.sv
// Shared types and constants for the rev_meter pulse-rate path.
package rev_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GATE = 1'b1
  } rev_state_t;

  // 100 ms gate at the 50 MHz board clock
  localparam int unsigned BOARD_CLK_HZ        = 50_000_000;
  localparam int unsigned GATE_CYCLES_DEFAULT = BOARD_CLK_HZ / 10;

endpackage

// File: rtl/rev_meter_pulse_debounce.sv
// Level filter: output follows the input only after it has differed from the
// output for DEB_CYCLES consecutive clocks.
module pulse_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] CNT_LOAD = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= CNT_LOAD;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= CNT_LOAD;
    end else if (cnt == '0) begin
      dout <= din;
      cnt  <= CNT_LOAD;
    end else begin
      cnt <= cnt - DW'(1);
    end
  end

endmodule

// File: rtl/rev_meter.sv
// Gated pulse-rate meter: counts synchronized rising edges of pulse_in per
// GATE_CYCLES window. Define REV_METER_DEBOUNCE_EN to insert pulse_debounce.
//
// state   | meaning
// ST_IDLE | gate counter, accumulator and saturation flag held clear
// ST_GATE | counting edges; window closes and publishes at g == GATE_CYCLES-1
module rev_meter
  import rev_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEB_CYCLES  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] rev_count,
  output logic             count_valid,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned    G_W    = $clog2(GATE_CYCLES);
  localparam logic [G_W-1:0] G_LAST = G_W'(GATE_CYCLES - 1);

  logic s_meta, s_sync, s_lvl, s_prev, edge_det;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s_meta <= pulse_in;
      s_sync <= s_meta;
      s_prev <= s_lvl;
    end
  end

`ifdef REV_METER_DEBOUNCE_EN
  pulse_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk  (clk),
    .rst  (rst),
    .din  (s_sync),
    .dout (s_lvl)
  );
`else
  // Filter length has no effect on the unfiltered path.
  if (DEB_CYCLES == 0) begin : g_deb_unused
  end
  assign s_lvl = s_sync;
`endif

  assign edge_det = s_lvl & ~s_prev;

  rev_state_t       state, state_nxt;
  logic [G_W-1:0]   g, g_nxt;
  logic [CNT_W-1:0] acc, acc_nxt, acc_inc, rev_count_nxt;
  logic             sat, sat_nxt, sum_sat, acc_full, ovf_nxt, valid_nxt;

  // Saturating add of this cycle's edge; an edge arriving at all-ones is lost
  assign acc_full = &acc;
  assign acc_inc  = (edge_det && !acc_full) ? acc + CNT_W'(1) : acc;
  assign sum_sat  = sat | (edge_det & acc_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      g           <= '0;
      acc         <= '0;
      sat         <= 1'b0;
      rev_count   <= '0;
      ovf         <= 1'b0;
      count_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      g           <= g_nxt;
      acc         <= acc_nxt;
      sat         <= sat_nxt;
      rev_count   <= rev_count_nxt;
      ovf         <= ovf_nxt;
      count_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    g_nxt         = g;
    acc_nxt       = acc;
    sat_nxt       = sat;
    rev_count_nxt = rev_count;
    ovf_nxt       = ovf;
    valid_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        g_nxt   = '0;
        acc_nxt = '0;
        sat_nxt = 1'b0;
        if (en) state_nxt = ST_GATE;
      end
      ST_GATE: begin
        if (!en) begin
          state_nxt = ST_IDLE;
          g_nxt     = '0;
          acc_nxt   = '0;
          sat_nxt   = 1'b0;
        end else if (g == G_LAST) begin
          // Closing cycle's edge is folded in; the next window starts clean
          rev_count_nxt = acc_inc;
          ovf_nxt       = sum_sat;
          valid_nxt     = 1'b1;
          g_nxt         = '0;
          acc_nxt       = '0;
          sat_nxt       = 1'b0;
        end else begin
          g_nxt   = g + G_W'(1);
          acc_nxt = acc_inc;
          sat_nxt = sum_sat;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_GATE);

endmodule

// File: tb/tb_rev_meter.sv
// Directed bench for rev_meter (GATE_CYCLES=100, CNT_W=4) with an
// expected-window scoreboard popped on each count_valid strobe.
module tb_rev_meter;

  localparam int GATE = 100;

  logic       clk = 1'b0;
  logic       rst, en, pulse_in;
  logic [3:0] rev_count;
  logic       count_valid, ovf, busy;

  typedef struct {
    logic [3:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert    = 0;
  int   n_fail      = 0;
  int   n_strobes   = 0;
  int   n_pushed    = 0;
  int   cyc         = 0;
  int   last_strobe = -1;

  rev_meter #(.GATE_CYCLES(GATE), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pulse_in    (pulse_in),
    .rev_count   (rev_count),
    .count_valid (count_valid),
    .ovf         (ovf),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] c, input logic o);
    exp_t e;
    e.cnt = c;
    e.ovf = o;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // Advance to the next falling edge and service the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (count_valid === 1'b1) begin
      n_strobes++;
      check("strobe_expected", 32'(exp_q.size()), 32'(exp_q.size() > 0 ? exp_q.size() : 1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rev_count", 32'(rev_count), 32'(e.cnt));
        check("ovf", 32'(ovf), 32'(e.ovf));
      end
      if (last_strobe >= 0) check("strobe_period", 32'(cyc - last_strobe), GATE);
      last_strobe = cyc;
    end
  endtask

  task automatic start_gate();
    tick();
    en = 1'b1;
    last_strobe = -1;
    check("busy_before_gate", 32'(busy), 0);
  endtask

  task automatic stop_gate(input logic [3:0] hold_cnt, input logic hold_ovf);
    en = 1'b0;
    pulse_in = 1'b0;
    tick();
    check("busy_after_stop", 32'(busy), 0);
    check("hold_rev_count", 32'(rev_count), 32'(hold_cnt));
    check("hold_ovf", 32'(ovf), 32'(hold_ovf));
    repeat (5) tick();
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    pulse_in = 1'b0;
    #1;
    check("rst_count_valid", 32'(count_valid), 0);

    // Reset dominates a toggling input and a high enable
    for (int i = 0; i < 8; i++) begin
      tick();
      pulse_in = ~pulse_in;
      en = 1'b1;
      check("rst_rev_count", 32'(rev_count), 0);
      check("rst_ovf", 32'(ovf), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_valid", 32'(count_valid), 0);
    end
    en = 1'b0;
    pulse_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();

    // Steady train: 10 pulses (2 high / 8 low) per window, three windows
    push(4'd10, 1'b0);
    push(4'd10, 1'b0);
    push(4'd10, 1'b0);
    start_gate();
    for (int i = 0; i < 310; i++) begin
      tick();
      if (i == 0) check("busy_after_en", 32'(busy), 1);
      pulse_in = (i < 300) && (i % 10 < 2);
    end
    stop_gate(4'd10, 1'b0);

    // Saturation: 20 edges then 3 edges
    push(4'd15, 1'b1);
    push(4'd3, 1'b0);
    start_gate();
    for (int i = 0; i < 210; i++) begin
      tick();
      pulse_in = ((i < 80) && (i % 4 < 2)) || ((i >= 100) && (i < 130) && (i % 10 < 2));
    end
    stop_gate(4'd3, 1'b0);

    // Window boundaries: edges land at gate cycles 99, 200 and 299
    push(4'd1, 1'b0);
    push(4'd0, 1'b0);
    push(4'd2, 1'b0);
    start_gate();
    for (int i = 0; i < 310; i++) begin
      tick();
      pulse_in = (i == 97) || (i == 198) || (i == 297);
    end
    stop_gate(4'd2, 1'b0);

    // Enable dropped mid-window: partial count discarded, no strobe
    start_gate();
    for (int i = 0; i < 50; i++) begin
      tick();
      pulse_in = (i % 10 < 2);
      if (i == 49) en = 1'b0;
    end
    tick();
    check("busy_drop", 32'(busy), 0);
    pulse_in = 1'b0;
    repeat (150) tick();
    check("drop_hold_count", 32'(rev_count), 2);
    check("drop_no_strobe", 32'(n_strobes), 32'(n_pushed));

    // Re-enable: a full fresh window
    push(4'd10, 1'b0);
    start_gate();
    for (int i = 0; i < 101; i++) begin
      tick();
      if (i == 99) check("fresh_no_early_valid", 32'(count_valid), 0);
      if (i == 100) check("fresh_valid_at_100", 32'(count_valid), 1);
      pulse_in = (i < 100) && (i % 10 < 2);
    end

    // Reset in the middle of a window
    for (int i = 101; i < 150; i++) begin
      tick();
      pulse_in = (i % 10 < 2);
    end
    rst = 1'b1;
    en = 1'b0;
    pulse_in = 1'b0;
    #1;
    check("midrst_rev_count", 32'(rev_count), 0);
    check("midrst_ovf", 32'(ovf), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_valid", 32'(count_valid), 0);
    repeat (5) tick();
    rst = 1'b0;
    repeat (120) tick();

    check("queue_drained", 32'(exp_q.size()), 0);
    check("strobe_total", 32'(n_strobes), 32'(n_pushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
